// File: rtl/video_timing_capture.sv
// -----------------------------------------------------------------------------
// video_timing_capture
//   Measures incoming video timing (sync widths, porches, active size, totals)
//   and publishes one coherent parameter set per frame, one cycle after each
//   input vsync rising edge, for the downstream video_sync_out_gen block.
//
// Ports
//   I_CLK, I_RSTN            pixel clock, asynchronous active-low reset
//   i_vsync/i_hsync/i_de     synchronous active-high video timing inputs
//   i_mirror_mode/i_blur_mode  mode request levels, latched at each vsync rise
//   o_vsync_sync             i_vsync delayed by one register
//   o_mirror_mode_cap/o_blur_mode_cap  latched mode levels
//   o_h*_cap, o_htotal       horizontal widths / clocks per line
//   o_v*_cap, o_vtotal       vertical widths / lines per frame
//   o_cap_valid              set at the first publication, held until reset
// -----------------------------------------------------------------------------
module video_timing_capture #(
    parameter int PARAM_WIDTH = 16
) (
    input  logic                   I_CLK,
    input  logic                   I_RSTN,
    input  logic                   i_vsync,
    input  logic                   i_hsync,
    input  logic                   i_de,
    input  logic                   i_mirror_mode,
    input  logic                   i_blur_mode,
    output logic                   o_vsync_sync,
    output logic                   o_mirror_mode_cap,
    output logic                   o_blur_mode_cap,
    output logic [PARAM_WIDTH-1:0] o_hsw_cap,
    output logic [PARAM_WIDTH-1:0] o_hbp_cap,
    output logic [PARAM_WIDTH-1:0] o_hact_cap,
    output logic [PARAM_WIDTH-1:0] o_hfp_cap,
    output logic [PARAM_WIDTH-1:0] o_vsw_cap,
    output logic [PARAM_WIDTH-1:0] o_vbp_cap,
    output logic [PARAM_WIDTH-1:0] o_vact_cap,
    output logic [PARAM_WIDTH-1:0] o_vfp_cap,
    output logic [PARAM_WIDTH-1:0] o_htotal,
    output logic [PARAM_WIDTH-1:0] o_vtotal,
    output logic                   o_cap_valid
);

    typedef logic [PARAM_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_ZERO = {PARAM_WIDTH{1'b0}};
    localparam cnt_t CNT_MAX  = {PARAM_WIDTH{1'b1}};
    localparam cnt_t CNT_ONE  = cnt_t'(1'b1);

    typedef enum logic [2:0] {
        H_IDLE = 3'd0,
        H_SYNC = 3'd1,
        H_BP   = 3'd2,
        H_ACT  = 3'd3,
        H_FP   = 3'd4
    } h_state_t;

    // Saturating increment: counters hold at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        cnt_t r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic vsync_dly_r, hsync_dly_r, de_dly_r;
    logic vs_rise_s, hs_rise_s, hs_fall_s, de_rise_s, de_fall_s;

    h_state_t h_state_r;
    cnt_t     hsw_cnt_r, hbp_cnt_r, hact_cnt_r, hfp_cnt_r, period_r;
    logic     de_seen_r, line_vs_r, line_open_r;
    logic     line_close_s;

    cnt_t hsw_w_r, hbp_w_r, hact_w_r, hfp_w_r, htot_w_r;
    cnt_t vsw_w_r, vbp_w_r, vact_w_r, vfp_w_r;
    logic act_seen_r, armed_r;

    cnt_t hsw_nx_s, hbp_nx_s, hact_nx_s, hfp_nx_s, htot_nx_s;
    cnt_t vsw_nx_s, vbp_nx_s, vact_nx_s, vfp_nx_s, vtot_nx_s;
    logic act_seen_nx_s;

    assign vs_rise_s    = i_vsync & ~vsync_dly_r;
    assign hs_rise_s    = i_hsync & ~hsync_dly_r;
    assign hs_fall_s    = ~i_hsync & hsync_dly_r;
    assign de_rise_s    = i_de & ~de_dly_r;
    assign de_fall_s    = ~i_de & de_dly_r;
    // The very first hsync rise after reset only opens a line.
    assign line_close_s = hs_rise_s & line_open_r;
    assign o_vsync_sync = vsync_dly_r;

    // One-cycle delayed copies of the timing inputs for edge detection.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            vsync_dly_r <= 1'b0;
            hsync_dly_r <= 1'b0;
            de_dly_r    <= 1'b0;
        end else begin
            vsync_dly_r <= i_vsync;
            hsync_dly_r <= i_hsync;
            de_dly_r    <= i_de;
        end
    end

    // Horizontal FSM and per-segment counters; each counter includes the cycle
    // on which its entry edge was detected. A fresh hsync rise restarts a line.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            h_state_r   <= H_IDLE;
            hsw_cnt_r   <= CNT_ZERO;
            hbp_cnt_r   <= CNT_ZERO;
            hact_cnt_r  <= CNT_ZERO;
            hfp_cnt_r   <= CNT_ZERO;
            period_r    <= CNT_ZERO;
            de_seen_r   <= 1'b0;
            line_vs_r   <= 1'b0;
            line_open_r <= 1'b0;
        end else if (hs_rise_s) begin
            h_state_r   <= H_SYNC;
            hsw_cnt_r   <= CNT_ONE;
            hbp_cnt_r   <= CNT_ZERO;
            hact_cnt_r  <= CNT_ZERO;
            hfp_cnt_r   <= CNT_ZERO;
            period_r    <= CNT_ONE;
            de_seen_r   <= 1'b0;
            line_vs_r   <= i_vsync;
            line_open_r <= 1'b1;
        end else begin
            period_r <= sat_inc(period_r);
            case (h_state_r)
                H_SYNC: begin
                    if (hs_fall_s && de_rise_s) begin
                        // Back porch entered and left in the same cycle: hbp stays 0.
                        h_state_r  <= H_ACT;
                        hact_cnt_r <= CNT_ONE;
                        de_seen_r  <= 1'b1;
                    end else if (hs_fall_s) begin
                        h_state_r <= H_BP;
                        hbp_cnt_r <= CNT_ONE;
                    end else begin
                        hsw_cnt_r <= sat_inc(hsw_cnt_r);
                    end
                end
                H_BP: begin
                    if (de_rise_s) begin
                        h_state_r  <= H_ACT;
                        hact_cnt_r <= CNT_ONE;
                        de_seen_r  <= 1'b1;
                    end else begin
                        hbp_cnt_r <= sat_inc(hbp_cnt_r);
                    end
                end
                H_ACT: begin
                    if (de_fall_s) begin
                        h_state_r <= H_FP;
                        hfp_cnt_r <= CNT_ONE;
                    end else begin
                        hact_cnt_r <= sat_inc(hact_cnt_r);
                    end
                end
                H_FP: begin
                    hfp_cnt_r <= sat_inc(hfp_cnt_r);
                end
                default: begin
                    h_state_r <= H_IDLE;
                end
            endcase
        end
    end

    // Next working values including the line closed this cycle, so a line
    // closed on the frame-boundary cycle still belongs to the ending frame.
    always_comb begin
        hsw_nx_s      = hsw_w_r;
        hbp_nx_s      = hbp_w_r;
        hact_nx_s     = hact_w_r;
        hfp_nx_s      = hfp_w_r;
        htot_nx_s     = htot_w_r;
        vsw_nx_s      = vsw_w_r;
        vbp_nx_s      = vbp_w_r;
        vact_nx_s     = vact_w_r;
        vfp_nx_s      = vfp_w_r;
        act_seen_nx_s = act_seen_r;
        if (line_close_s) begin
            if (de_seen_r) begin
                hsw_nx_s  = hsw_cnt_r;
                hbp_nx_s  = hbp_cnt_r;
                hact_nx_s = hact_cnt_r;
                hfp_nx_s  = hfp_cnt_r;
                htot_nx_s = period_r;
            end else begin
                htot_nx_s = htot_w_r;
            end
            if (line_vs_r) begin
                vsw_nx_s = sat_inc(vsw_w_r);
            end else if (de_seen_r) begin
                vact_nx_s     = sat_inc(vact_w_r);
                act_seen_nx_s = 1'b1;
            end else if (!act_seen_r) begin
                vbp_nx_s = sat_inc(vbp_w_r);
            end else begin
                vfp_nx_s = sat_inc(vfp_w_r);
            end
        end else begin
            act_seen_nx_s = act_seen_r;
        end
        vtot_nx_s = vsw_nx_s + vbp_nx_s + vact_nx_s + vfp_nx_s;
    end

    // Working registers and per-frame publication. The first vsync rise only
    // arms; every later rise loads all outputs together.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            hsw_w_r           <= CNT_ZERO;
            hbp_w_r           <= CNT_ZERO;
            hact_w_r          <= CNT_ZERO;
            hfp_w_r           <= CNT_ZERO;
            htot_w_r          <= CNT_ZERO;
            vsw_w_r           <= CNT_ZERO;
            vbp_w_r           <= CNT_ZERO;
            vact_w_r          <= CNT_ZERO;
            vfp_w_r           <= CNT_ZERO;
            act_seen_r        <= 1'b0;
            armed_r           <= 1'b0;
            o_mirror_mode_cap <= 1'b0;
            o_blur_mode_cap   <= 1'b0;
            o_hsw_cap         <= CNT_ZERO;
            o_hbp_cap         <= CNT_ZERO;
            o_hact_cap        <= CNT_ZERO;
            o_hfp_cap         <= CNT_ZERO;
            o_vsw_cap         <= CNT_ZERO;
            o_vbp_cap         <= CNT_ZERO;
            o_vact_cap        <= CNT_ZERO;
            o_vfp_cap         <= CNT_ZERO;
            o_htotal          <= CNT_ZERO;
            o_vtotal          <= CNT_ZERO;
            o_cap_valid       <= 1'b0;
        end else begin
            hsw_w_r  <= hsw_nx_s;
            hbp_w_r  <= hbp_nx_s;
            hact_w_r <= hact_nx_s;
            hfp_w_r  <= hfp_nx_s;
            htot_w_r <= htot_nx_s;
            if (vs_rise_s) begin
                vsw_w_r           <= CNT_ZERO;
                vbp_w_r           <= CNT_ZERO;
                vact_w_r          <= CNT_ZERO;
                vfp_w_r           <= CNT_ZERO;
                act_seen_r        <= 1'b0;
                armed_r           <= 1'b1;
                o_mirror_mode_cap <= i_mirror_mode;
                o_blur_mode_cap   <= i_blur_mode;
                if (armed_r) begin
                    o_hsw_cap   <= hsw_nx_s;
                    o_hbp_cap   <= hbp_nx_s;
                    o_hact_cap  <= hact_nx_s;
                    o_hfp_cap   <= hfp_nx_s;
                    o_vsw_cap   <= vsw_nx_s;
                    o_vbp_cap   <= vbp_nx_s;
                    o_vact_cap  <= vact_nx_s;
                    o_vfp_cap   <= vfp_nx_s;
                    o_htotal    <= htot_nx_s;
                    o_vtotal    <= vtot_nx_s;
                    o_cap_valid <= 1'b1;
                end
            end else begin
                vsw_w_r    <= vsw_nx_s;
                vbp_w_r    <= vbp_nx_s;
                vact_w_r   <= vact_nx_s;
                vfp_w_r    <= vfp_nx_s;
                act_seen_r <= act_seen_nx_s;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_capture.sv
// -----------------------------------------------------------------------------
// tb_video_timing_capture
//   Directed-vector bench: generates small synthetic frames with known sync,
//   porch and active sizes and compares the published parameter set against
//   hand-computed values at each vsync boundary.
// -----------------------------------------------------------------------------
module tb_video_timing_capture;

    localparam int PW = 16;

    logic          I_CLK = 1'b0;
    logic          I_RSTN = 1'b0;
    logic          i_vsync = 1'b0;
    logic          i_hsync = 1'b0;
    logic          i_de = 1'b0;
    logic          i_mirror_mode = 1'b0;
    logic          i_blur_mode = 1'b0;
    logic          o_vsync_sync;
    logic          o_mirror_mode_cap;
    logic          o_blur_mode_cap;
    logic [PW-1:0] o_hsw_cap, o_hbp_cap, o_hact_cap, o_hfp_cap;
    logic [PW-1:0] o_vsw_cap, o_vbp_cap, o_vact_cap, o_vfp_cap;
    logic [PW-1:0] o_htotal, o_vtotal;
    logic          o_cap_valid;

    int n_vec = 0;
    int n_err = 0;

    video_timing_capture #(.PARAM_WIDTH(PW)) dut (
        .I_CLK             (I_CLK),
        .I_RSTN            (I_RSTN),
        .i_vsync           (i_vsync),
        .i_hsync           (i_hsync),
        .i_de              (i_de),
        .i_mirror_mode     (i_mirror_mode),
        .i_blur_mode       (i_blur_mode),
        .o_vsync_sync      (o_vsync_sync),
        .o_mirror_mode_cap (o_mirror_mode_cap),
        .o_blur_mode_cap   (o_blur_mode_cap),
        .o_hsw_cap         (o_hsw_cap),
        .o_hbp_cap         (o_hbp_cap),
        .o_hact_cap        (o_hact_cap),
        .o_hfp_cap         (o_hfp_cap),
        .o_vsw_cap         (o_vsw_cap),
        .o_vbp_cap         (o_vbp_cap),
        .o_vact_cap        (o_vact_cap),
        .o_vfp_cap         (o_vfp_cap),
        .o_htotal          (o_htotal),
        .o_vtotal          (o_vtotal),
        .o_cap_valid       (o_cap_valid)
    );

    // Pixel clock.
    always #5 I_CLK = ~I_CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_caps(input string tag, input int hsw, input int hbp, input int hact,
                              input int hfp, input int htot, input int vsw, input int vbp,
                              input int vact, input int vfp, input int vtot, input int valid);
        check_val({tag, "_hsw"},   32'(o_hsw_cap),   32'(hsw));
        check_val({tag, "_hbp"},   32'(o_hbp_cap),   32'(hbp));
        check_val({tag, "_hact"},  32'(o_hact_cap),  32'(hact));
        check_val({tag, "_hfp"},   32'(o_hfp_cap),   32'(hfp));
        check_val({tag, "_htot"},  32'(o_htotal),    32'(htot));
        check_val({tag, "_vsw"},   32'(o_vsw_cap),   32'(vsw));
        check_val({tag, "_vbp"},   32'(o_vbp_cap),   32'(vbp));
        check_val({tag, "_vact"},  32'(o_vact_cap),  32'(vact));
        check_val({tag, "_vfp"},   32'(o_vfp_cap),   32'(vfp));
        check_val({tag, "_vtot"},  32'(o_vtotal),    32'(vtot));
        check_val({tag, "_valid"}, 32'(o_cap_valid), 32'(valid));
    endtask

    // Drive one cycle of inputs; return 1 time unit after the sampling edge.
    task automatic step(input logic vs, input logic hs, input logic de);
        i_vsync = vs;
        i_hsync = hs;
        i_de    = de;
        @(posedge I_CLK);
        #1;
    endtask

    // Cycles [from,to) of a line: hsync 4 clocks, then hbp, hact (de), hfp.
    task automatic run_line(input logic vs, input int hbp, input int hact, input int hfp,
                            input bit de_on, input int from, input int to);
        for (int c = from; c < to; c++) begin
            step(vs, (c < 4), de_on && (c >= 4 + hbp) && (c < 4 + hbp + hact));
        end
    endtask

    // First cycle of a frame: vsync and hsync rise together.
    task automatic boundary();
        step(1'b1, 1'b1, 1'b0);
    endtask

    // Remainder of a frame whose first cycle was issued by boundary().
    // Lines at index >= sw use hact2; mir_late raises mirror 3 cycles before the end.
    task automatic do_frame(input int vsw, input int vbp, input int vact, input int vfp,
                            input int hbp, input int hact, input int hact2, input int sw,
                            input bit mir_late);
        int  nl;
        int  ha;
        int  tot;
        int  from;
        logic vs;
        bit  de_on;
        nl = vsw + vbp + vact + vfp;
        for (int l = 0; l < nl; l++) begin
            vs    = (l < vsw);
            de_on = (l >= vsw + vbp) && (l < vsw + vbp + vact);
            ha    = (l >= sw) ? hact2 : hact;
            tot   = 4 + hbp + ha + 10;
            from  = (l == 0) ? 1 : 0;
            if (l == vsw) begin
                check_val("vsync_sync_hi", 32'(o_vsync_sync), 32'd1);
                run_line(vs, hbp, ha, 10, de_on, 0, 1);
                check_val("vsync_sync_lo", 32'(o_vsync_sync), 32'd0);
                from = 1;
            end
            if (mir_late && (l == nl - 1)) begin
                run_line(vs, hbp, ha, 10, de_on, from, tot - 3);
                i_mirror_mode = 1'b1;
                run_line(vs, hbp, ha, 10, de_on, tot - 3, tot);
            end else begin
                run_line(vs, hbp, ha, 10, de_on, from, tot);
            end
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge I_CLK);
        #1;
        check_caps("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("rst_vss", 32'(o_vsync_sync), 32'd0);
        check_val("rst_mir", 32'(o_mirror_mode_cap), 32'd0);
        I_RSTN = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Arming rise: nothing published.
        boundary();
        check_val("arm_vss", 32'(o_vsync_sync), 32'd1);
        check_val("arm_valid", 32'(o_cap_valid), 32'd0);
        check_val("arm_hact", 32'(o_hact_cap), 32'd0);
        do_frame(2, 3, 8, 2, 6, 20, 20, 100, 1'b0);
        check_caps("pre2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Second rise: first publication of the steady frame.
        boundary();
        check_caps("r2", 4, 6, 20, 10, 40, 2, 3, 8, 2, 15, 1);
        check_val("r2_mir", 32'(o_mirror_mode_cap), 32'd0);

        // hact changes to 24 mid-frame; outputs hold until the boundary.
        do_frame(2, 3, 8, 2, 6, 20, 24, 7, 1'b1);
        check_val("mid_hact", 32'(o_hact_cap), 32'd20);
        check_val("mid_htot", 32'(o_htotal), 32'd40);
        check_val("mid_mir", 32'(o_mirror_mode_cap), 32'd0);
        boundary();
        check_caps("r3", 4, 6, 24, 10, 44, 2, 3, 8, 2, 15, 1);
        check_val("r3_mir", 32'(o_mirror_mode_cap), 32'd1);
        check_val("r3_blur", 32'(o_blur_mode_cap), 32'd0);
        i_mirror_mode = 1'b0;
        i_blur_mode   = 1'b1;

        do_frame(2, 3, 8, 2, 6, 24, 24, 100, 1'b0);
        check_val("hold_mir", 32'(o_mirror_mode_cap), 32'd1);
        boundary();
        check_val("r4_mir", 32'(o_mirror_mode_cap), 32'd0);
        check_val("r4_blur", 32'(o_blur_mode_cap), 32'd1);
        check_val("r4_hact", 32'(o_hact_cap), 32'd24);
        i_blur_mode = 1'b0;

        // Different vertical structure.
        do_frame(1, 2, 5, 4, 6, 20, 20, 100, 1'b0);
        boundary();
        check_caps("r5", 4, 6, 20, 10, 40, 1, 2, 5, 4, 12, 1);
        check_val("r5_blur", 32'(o_blur_mode_cap), 32'd0);

        // de rises in the hsync-fall cycle: hbp = 0.
        do_frame(2, 3, 8, 2, 0, 20, 20, 100, 1'b0);
        boundary();
        check_caps("r6", 4, 0, 20, 10, 34, 2, 3, 8, 2, 15, 1);

        // Reset mid-frame: outputs clear immediately.
        run_line(1'b1, 0, 20, 10, 1'b0, 1, 34);
        run_line(1'b1, 0, 20, 10, 1'b0, 0, 34);
        run_line(1'b0, 0, 20, 10, 1'b1, 0, 15);
        #2;
        I_RSTN  = 1'b0;
        i_vsync = 1'b0;
        i_hsync = 1'b0;
        i_de    = 1'b0;
        #1;
        check_caps("mrst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge I_CLK);
        #1;
        I_RSTN = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        boundary();
        check_val("rearm_valid", 32'(o_cap_valid), 32'd0);
        check_val("rearm_hact", 32'(o_hact_cap), 32'd0);
        do_frame(2, 3, 8, 2, 6, 20, 20, 100, 1'b0);
        boundary();
        check_caps("rpub", 4, 6, 20, 10, 40, 2, 3, 8, 2, 15, 1);

        // 70000-clock line: period and hfp saturate at 65535.
        run_line(1'b1, 6, 20, 10, 1'b0, 1, 40);
        run_line(1'b1, 6, 20, 10, 1'b0, 0, 40);
        run_line(1'b0, 6, 20, 69970, 1'b1, 0, 70000);
        boundary();
        check_caps("sat", 4, 6, 20, 65535, 65535, 2, 0, 1, 0, 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
